// File: rtl/ofdm_pkg.sv
// Shared types and constants for the OFDM transmit-frame scheduler.
// Samples are 16-bit complex words packed as {Im[15:8], Re[7:0]}.
package ofdm_pkg;

  localparam int SAMPLE_W = 16;
  localparam int STS_LEN  = 160;
  localparam int LTS_LEN  = 161;
  localparam int SYM_LEN  = 80;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STS,
    ST_LTS,
    ST_DATA,
    ST_DONE
  } frame_st_t;

endpackage

// File: rtl/ofdm_src_mux.sv
// Registered 3:1 sample mux driven by the frame state, plus the per-section
// sample counter that the top uses for its length check.
module ofdm_src_mux
  import ofdm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  frame_st_t   state,
  input  logic        clr,
  input  sample_t     sts_dout,
  input  logic        sts_vld,
  input  logic        sts_last,
  input  sample_t     lts_dout,
  input  logic        lts_vld,
  input  logic        lts_last,
  input  sample_t     data_dout,
  input  logic        data_vld,
  input  logic        data_last,
  output logic        sel_vld,
  output logic        sel_last,
  output sample_t     frame_dout,
  output logic        frame_dout_vld,
  output logic [15:0] sec_cnt
);

  sample_t sel_dout;

  // Only the source owning the current state is looked at; stray valids are dropped here.
  always_comb begin
    sel_dout = '0;
    sel_vld  = 1'b0;
    sel_last = 1'b0;
    case (state)
      ST_STS: begin
        sel_dout = sts_dout;
        sel_vld  = sts_vld;
        sel_last = sts_last;
      end
      ST_LTS: begin
        sel_dout = lts_dout;
        sel_vld  = lts_vld;
        sel_last = lts_last;
      end
      ST_DATA: begin
        sel_dout = data_dout;
        sel_vld  = data_vld;
        sel_last = data_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_dout     <= '0;
      frame_dout_vld <= 1'b0;
      sec_cnt        <= '0;
    end else if (clr) begin
      frame_dout_vld <= 1'b0;
      sec_cnt        <= '0;
    end else begin
      frame_dout_vld <= sel_vld;
      if (sel_vld) begin
        frame_dout <= sel_dout;
        if (sel_last)
          sec_cnt <= '0;
        else if (sec_cnt != 16'hFFFF)
          sec_cnt <= sec_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/ofdm_tx_frame_sched.sv
// Transmit-frame scheduler: walks STS -> LTS -> DATA symbols, grants each source
// in turn and merges their samples into one indexed, registered frame stream.
module ofdm_tx_frame_sched #(
  parameter int STS_LEN = ofdm_pkg::STS_LEN,
  parameter int LTS_LEN = ofdm_pkg::LTS_LEN,
  parameter int SYM_LEN = ofdm_pkg::SYM_LEN,
  parameter int NSYM_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_start,
  input  logic              tx_abort,
  input  logic [NSYM_W-1:0] tx_nsym,
  input  logic              dout_rdy,
  output logic              STS_din_rdy,
  input  logic [15:0]       STS_dout,
  input  logic              STS_dout_vld,
  input  logic              STS_dout_last,
  output logic              LTS_din_rdy,
  input  logic [15:0]       LTS_dout,
  input  logic              LTS_dout_vld,
  input  logic              LTS_dout_last,
  output logic              DATA_din_rdy,
  input  logic [15:0]       DATA_dout,
  input  logic              DATA_dout_vld,
  input  logic              DATA_dout_last,
  output logic [15:0]       frame_dout,
  output logic              frame_dout_vld,
  output logic              frame_dout_last,
  output logic [15:0]       frame_Index,
  output logic              frame_busy,
  output logic              frame_err
);

  ofdm_pkg::frame_st_t state;
  logic [NSYM_W-1:0]   nsym_r;
  logic [NSYM_W-1:0]   sym_cnt;
  logic [15:0]         index_cnt;
  logic [15:0]         sec_cnt;
  logic [15:0]         sec_len;
  logic                sel_vld;
  logic                sel_last;
  logic                start_acc;
  logic                clr;
  logic                accept;
  logic                sec_end;
  logic                last_sym;
  logic                frame_end;

  assign start_acc = (state == ofdm_pkg::ST_IDLE) & tx_start & ~tx_abort;
  assign clr       = tx_abort | start_acc;
  assign accept    = sel_vld & ~tx_abort;
  assign sec_end   = accept & sel_last;
  assign last_sym  = (sym_cnt == nsym_r - NSYM_W'(1));
  assign frame_end = sec_end &
                     (((state == ofdm_pkg::ST_LTS) && (nsym_r == '0)) ||
                      ((state == ofdm_pkg::ST_DATA) && last_sym));

  assign STS_din_rdy  = (state == ofdm_pkg::ST_STS)  & dout_rdy;
  assign LTS_din_rdy  = (state == ofdm_pkg::ST_LTS)  & dout_rdy;
  assign DATA_din_rdy = (state == ofdm_pkg::ST_DATA) & dout_rdy;
  assign frame_busy   = (state != ofdm_pkg::ST_IDLE);

  always_comb begin
    sec_len = 16'(SYM_LEN);
    case (state)
      ofdm_pkg::ST_STS: sec_len = 16'(STS_LEN);
      ofdm_pkg::ST_LTS: sec_len = 16'(LTS_LEN);
      default:          sec_len = 16'(SYM_LEN);
    endcase
  end

  ofdm_src_mux u_mux (
    .clk            (clk),
    .rst_n          (rst_n),
    .state          (state),
    .clr            (clr),
    .sts_dout       (STS_dout),
    .sts_vld        (STS_dout_vld),
    .sts_last       (STS_dout_last),
    .lts_dout       (LTS_dout),
    .lts_vld        (LTS_dout_vld),
    .lts_last       (LTS_dout_last),
    .data_dout      (DATA_dout),
    .data_vld       (DATA_dout_vld),
    .data_last      (DATA_dout_last),
    .sel_vld        (sel_vld),
    .sel_last       (sel_last),
    .frame_dout     (frame_dout),
    .frame_dout_vld (frame_dout_vld),
    .sec_cnt        (sec_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ofdm_pkg::ST_IDLE;
      nsym_r          <= '0;
      sym_cnt         <= '0;
      index_cnt       <= '0;
      frame_Index     <= '0;
      frame_dout_last <= 1'b0;
      frame_err       <= 1'b0;
    end else if (tx_abort) begin
      state           <= ofdm_pkg::ST_IDLE;
      sym_cnt         <= '0;
      index_cnt       <= '0;
      frame_Index     <= '0;
      frame_dout_last <= 1'b0;
    end else begin
      frame_dout_last <= frame_end;
      // frame_Index is aligned with the sample it labels, so it takes the pre-increment count.
      if (accept) begin
        frame_Index <= index_cnt;
        if (index_cnt != 16'hFFFF)
          index_cnt <= index_cnt + 16'd1;
      end
      if (sec_end && (sec_cnt + 16'd1 != sec_len))
        frame_err <= 1'b1;

      case (state)
        ofdm_pkg::ST_IDLE: begin
          if (tx_start) begin
            nsym_r      <= tx_nsym;
            sym_cnt     <= '0;
            index_cnt   <= '0;
            frame_Index <= '0;
            frame_err   <= 1'b0;
            state       <= ofdm_pkg::ST_STS;
          end
        end
        ofdm_pkg::ST_STS: begin
          if (sec_end) state <= ofdm_pkg::ST_LTS;
        end
        ofdm_pkg::ST_LTS: begin
          if (sec_end)
            state <= (nsym_r != '0) ? ofdm_pkg::ST_DATA : ofdm_pkg::ST_DONE;
        end
        ofdm_pkg::ST_DATA: begin
          if (sec_end) begin
            sym_cnt <= sym_cnt + NSYM_W'(1);
            if (last_sym) state <= ofdm_pkg::ST_DONE;
          end
        end
        ofdm_pkg::ST_DONE: state <= ofdm_pkg::ST_IDLE;
        default:           state <= ofdm_pkg::ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ofdm_tx_frame_sched.sv
// Directed bench for the frame scheduler: behavioural STS/LTS/DATA sources with
// 1-cycle rdy->vld latency and tagged samples so order and loss are visible.
module tb_ofdm_tx_frame_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tx_start, tx_abort, dout_rdy;
  logic [7:0]  tx_nsym;
  logic        STS_din_rdy, LTS_din_rdy, DATA_din_rdy;
  logic [15:0] sts_dout, lts_dout, dat_dout;
  logic        sts_vld, sts_last, lts_vld, lts_last, dat_vld, dat_last;
  logic [15:0] frame_dout, frame_Index;
  logic        frame_dout_vld, frame_dout_last, frame_busy, frame_err;
  logic [38:0] outs_vec;

  int n_checks = 0;
  int n_errors = 0;
  int sts_n, lts_n, dat_n;
  int lts_len_m, nsym_m, exp_lts_len;
  bit src_clr;
  int n_vld, seq_bad, last_cnt, last_at, grant_low, grant_miss, data_seen, err_lts, err_data;
  bit done_ok;

  always #5 clk = ~clk;

  ofdm_tx_frame_sched dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .tx_start        (tx_start),
    .tx_abort        (tx_abort),
    .tx_nsym         (tx_nsym),
    .dout_rdy        (dout_rdy),
    .STS_din_rdy     (STS_din_rdy),
    .STS_dout        (sts_dout),
    .STS_dout_vld    (sts_vld),
    .STS_dout_last   (sts_last),
    .LTS_din_rdy     (LTS_din_rdy),
    .LTS_dout        (lts_dout),
    .LTS_dout_vld    (lts_vld),
    .LTS_dout_last   (lts_last),
    .DATA_din_rdy    (DATA_din_rdy),
    .DATA_dout       (dat_dout),
    .DATA_dout_vld   (dat_vld),
    .DATA_dout_last  (dat_last),
    .frame_dout      (frame_dout),
    .frame_dout_vld  (frame_dout_vld),
    .frame_dout_last (frame_dout_last),
    .frame_Index     (frame_Index),
    .frame_busy      (frame_busy),
    .frame_err       (frame_err)
  );

  assign outs_vec = {frame_dout, frame_dout_vld, frame_dout_last, frame_Index,
                     frame_busy, frame_err, STS_din_rdy, LTS_din_rdy, DATA_din_rdy};

  // Source models: emit one sample the cycle after their grant is seen.
  always @(posedge clk) begin
    if (src_clr) begin
      sts_n <= 0; lts_n <= 0; dat_n <= 0;
      sts_vld <= 1'b0; sts_last <= 1'b0; sts_dout <= '0;
      lts_vld <= 1'b0; lts_last <= 1'b0; lts_dout <= '0;
      dat_vld <= 1'b0; dat_last <= 1'b0; dat_dout <= '0;
    end else begin
      if (STS_din_rdy && sts_n < 160) begin
        sts_vld <= 1'b1; sts_dout <= 16'h1000 + 16'(sts_n);
        sts_last <= (sts_n == 159); sts_n <= sts_n + 1;
      end else begin
        sts_vld <= 1'b0; sts_last <= 1'b0;
      end
      if (LTS_din_rdy && lts_n < lts_len_m) begin
        lts_vld <= 1'b1; lts_dout <= 16'h2000 + 16'(lts_n);
        lts_last <= (lts_n == lts_len_m - 1); lts_n <= lts_n + 1;
      end else begin
        lts_vld <= 1'b0; lts_last <= 1'b0;
      end
      if (DATA_din_rdy && dat_n < nsym_m * 80) begin
        dat_vld <= 1'b1; dat_dout <= 16'h4000 + 16'(dat_n);
        dat_last <= (dat_n % 80 == 79); dat_n <= dat_n + 1;
      end else begin
        dat_vld <= 1'b0; dat_last <= 1'b0;
      end
    end
  end

  function automatic logic [15:0] exp_sample(input int i);
    if (i < 160)               return 16'h1000 + 16'(i);
    if (i < 160 + exp_lts_len) return 16'h2000 + 16'(i - 160);
    return 16'h4000 + 16'(i - 160 - exp_lts_len);
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_frame(input int nsym, input int lts_len);
    nsym_m = nsym; lts_len_m = lts_len; exp_lts_len = lts_len;
    dout_rdy = 1'b1; tx_nsym = 8'(nsym); tx_start = 1'b1; src_clr = 1'b1;
    @(negedge clk);
    tx_start = 1'b0; src_clr = 1'b0;
  endtask

  // Follows one frame until busy drops or stop_idx is shown; pulses tx_start after pulse_idx.
  task automatic watch(input bit toggle, input int stop_idx, input int pulse_idx);
    n_vld = 0; seq_bad = 0; last_cnt = 0; last_at = -1; grant_low = 0; grant_miss = 0;
    data_seen = 0; err_lts = -1; err_data = -1; done_ok = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      tx_start = 1'b0;
      if ((STS_din_rdy | LTS_din_rdy | DATA_din_rdy) && !dout_rdy) grant_low++;
      if (frame_busy && dout_rdy && !(STS_din_rdy | LTS_din_rdy | DATA_din_rdy)) grant_miss++;
      if (DATA_din_rdy) data_seen = 1;
      if (frame_dout_vld) begin
        if (frame_Index !== 16'(n_vld) || frame_dout !== exp_sample(n_vld)) seq_bad++;
        if (frame_dout_last) begin last_cnt++; last_at = n_vld; end
        if (n_vld == 160) err_lts = int'(frame_err);
        if (n_vld == 160 + exp_lts_len) err_data = int'(frame_err);
        if (n_vld == pulse_idx) begin tx_nsym = 8'd7; tx_start = 1'b1; end
        if (n_vld == stop_idx) begin done_ok = 1; return; end
        n_vld++;
      end
      if (!frame_busy) begin
        done_ok = 1;
        $display("frame: samples=%0d last_at=%0d seq_bad=%0d err=%0b", n_vld, last_at, seq_bad, frame_err);
        return;
      end
      if (toggle) dout_rdy = ~dout_rdy;
    end
  endtask

  initial begin
    rst_n = 1'b0; tx_start = 1'b0; tx_abort = 1'b0; tx_nsym = '0; dout_rdy = 1'b1;
    src_clr = 1'b1; lts_len_m = 161; nsym_m = 0; exp_lts_len = 161;
    repeat (3) @(negedge clk);
    check_val("reset_outputs", 64'(outs_vec), 64'd0);
    rst_n = 1'b1; src_clr = 1'b0;
    @(negedge clk);

    // 1: nominal two-symbol frame
    start_frame(2, 161);
    watch(1'b0, -1, -1);
    check_val("t1_done", 64'(done_ok), 64'd1);
    check_val("t1_count", 64'(n_vld), 64'd481);
    check_val("t1_sequence", 64'(seq_bad), 64'd0);
    check_val("t1_last_cnt", 64'(last_cnt), 64'd1);
    check_val("t1_last_at", 64'(last_at), 64'd480);
    check_val("t1_err", 64'(frame_err), 64'd0);
    check_val("t1_final_index", 64'(frame_Index), 64'd480);
    check_val("t1_grant_low", 64'(grant_low), 64'd0);

    // 2: preamble only
    start_frame(0, 161);
    watch(1'b0, -1, -1);
    check_val("t2_count", 64'(n_vld), 64'd321);
    check_val("t2_data_rdy", 64'(data_seen), 64'd0);
    check_val("t2_last_at", 64'(last_at), 64'd320);
    check_val("t2_last_cnt", 64'(last_cnt), 64'd1);
    check_val("t2_sequence", 64'(seq_bad), 64'd0);

    // 3: downstream ready toggling every cycle
    start_frame(2, 161);
    watch(1'b1, -1, -1);
    check_val("t3_done", 64'(done_ok), 64'd1);
    check_val("t3_count", 64'(n_vld), 64'd481);
    check_val("t3_sequence", 64'(seq_bad), 64'd0);
    check_val("t3_last_at", 64'(last_at), 64'd480);
    check_val("t3_grant_low", 64'(grant_low), 64'd0);
    check_val("t3_grant_miss_le1", 64'(grant_miss <= 1), 64'd1);

    // 4: abort mid-LTS, then start+abort together, then a clean frame
    start_frame(2, 161);
    watch(1'b0, 200, -1);
    check_val("t4_reached_200", 64'(done_ok), 64'd1);
    tx_abort = 1'b1;
    @(negedge clk);
    tx_abort = 1'b0;
    check_val("t4_abort_state", 64'({STS_din_rdy, LTS_din_rdy, DATA_din_rdy, frame_dout_vld, frame_busy}), 64'd0);
    tx_start = 1'b1; tx_abort = 1'b1;
    @(negedge clk);
    tx_start = 1'b0; tx_abort = 1'b0;
    check_val("t4_start_abort_idle", 64'(frame_busy), 64'd0);
    start_frame(1, 161);
    watch(1'b0, -1, -1);
    check_val("t4_restart_count", 64'(n_vld), 64'd401);
    check_val("t4_restart_sequence", 64'(seq_bad), 64'd0);
    check_val("t4_restart_last_at", 64'(last_at), 64'd400);

    // 5: short LTS section flags a length error but the frame continues
    start_frame(1, 150);
    watch(1'b0, -1, -1);
    check_val("t5_err_before_lts_end", 64'(err_lts), 64'd0);
    check_val("t5_err_in_data", 64'(err_data), 64'd1);
    check_val("t5_count", 64'(n_vld), 64'd390);
    check_val("t5_sequence", 64'(seq_bad), 64'd0);
    check_val("t5_err_sticky", 64'(frame_err), 64'd1);
    start_frame(0, 161);
    check_val("t5_err_cleared", 64'(frame_err), 64'd0);
    watch(1'b0, -1, -1);
    check_val("t5_clean_err", 64'(frame_err), 64'd0);

    // 6: ignored mid-frame start, then asynchronous reset at index 50
    start_frame(2, 161);
    watch(1'b0, 50, 20);
    check_val("t6_reached_50", 64'(done_ok), 64'd1);
    check_val("t6_start_ignored", 64'(seq_bad), 64'd0);
    #2 rst_n = 1'b0;
    #1 check_val("t6_async_reset", 64'(outs_vec), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("t6_idle_after_reset", 64'(frame_busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
